// File: rtl/addsub_disp_pkg.sv
// Shared constants for the add/sub result display: glyph codes,
// active-low segment patterns and the default digit refresh period.
package addsub_disp_pkg;

    // Default dwell per digit: 1 kHz per digit from a 100 MHz clock
    localparam int REFRESH_DIV_DEFAULT = 100000;

    // Glyph codes fed to the segment decoder; 0..9 are the decimal digits
    localparam logic [4:0] GLYPH_A     = 5'd10;
    localparam logic [4:0] GLYPH_S     = 5'd11;
    localparam logic [4:0] GLYPH_MINUS = 5'd12;
    localparam logic [4:0] GLYPH_BLANK = 5'd13;

    // Active-low segment patterns, bit order g,f,e,d,c,b,a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph-code to active-low seven-segment decoder.
module seg7_decode
    import addsub_disp_pkg::*;
(
    input  logic [4:0] glyph,
    output logic [6:0] seg
);

    // Map each glyph code to its segment pattern; unknown codes stay dark
    always_comb begin
        seg = SEG_BLANK;
        case (glyph)
            5'd0:        seg = SEG_0;
            5'd1:        seg = SEG_1;
            5'd2:        seg = SEG_2;
            5'd3:        seg = SEG_3;
            5'd4:        seg = SEG_4;
            5'd5:        seg = SEG_5;
            5'd6:        seg = SEG_6;
            5'd7:        seg = SEG_7;
            5'd8:        seg = SEG_8;
            5'd9:        seg = SEG_9;
            GLYPH_A:     seg = SEG_A;
            GLYPH_S:     seg = SEG_S;
            GLYPH_MINUS: seg = SEG_MINUS;
            default:     seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/addsub_seg_display.sv
// Four-digit multiplexed display of a 4-bit add/sub result: mode letter,
// sign, tens and ones, scanned right to left with registered outputs.
module addsub_seg_display
    import addsub_disp_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] sum,
    input  logic       m,
    input  logic       load,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             wrap;
    logic [4:0]       sum_p0;
    logic             m_p0;
    logic             neg;
    logic [4:0]       mag;
    logic [1:0]       tens;
    logic [3:0]       ones;
    logic [4:0]       glyph;
    logic [6:0]       seg_next;

    assign wrap = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign dp   = 1'b1;

    // Refresh counter and scan index; the index steps once per full dwell
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (wrap) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // ---- stage p0: captured result and mode ----
    // Hold the last loaded result until the next load strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_p0 <= 5'd0;
            m_p0   <= 1'b0;
        end else if (load) begin
            sum_p0 <= sum;
            m_p0   <= m;
        end
    end

    // Only subtract mode treats the top bit as a sign; -16 negates to 16
    assign neg = m_p0 & sum_p0[4];
    assign mag = neg ? (~sum_p0 + 5'd1) : sum_p0;

    // Split the magnitude into tens and ones by range compare
    always_comb begin
        tens = 2'd0;
        ones = mag[3:0];
        if (mag >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(mag - 5'd30);
        end else if (mag >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(mag - 5'd20);
        end else if (mag >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(mag - 5'd10);
        end
    end

    // Choose the glyph for the digit currently being scanned
    always_comb begin
        glyph = GLYPH_BLANK;
        case (idx)
            2'd3: glyph = m_p0 ? GLYPH_S : GLYPH_A;
            2'd2: glyph = neg ? GLYPH_MINUS : GLYPH_BLANK;
            2'd1: glyph = (tens == 2'd0) ? GLYPH_BLANK : {3'b000, tens};
            default: glyph = {1'b0, ones};
        endcase
    end

    seg7_decode u_seg7_decode (
        .glyph (glyph),
        .seg   (seg_next)
    );

    // ---- stage p1: registered digit enable and segments ----
    // One-cycle registered view of the scan index and held value
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_addsub_seg_display.sv
// Self-checking bench for addsub_seg_display with a 4-cycle digit dwell.
module tb_addsub_seg_display;

    localparam int DIV = 4;

    typedef struct {
        logic [4:0] sum;
        logic       m;
        logic [6:0] digs [4];   // expected seg for digit 0..3
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] sum = 5'd0;
    logic       m = 1'b0;
    logic       load = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int passed = 0;

    // Reference state: held value and edges elapsed since reset released
    logic [4:0] ref_sum = 5'd0;
    logic       ref_m = 1'b0;
    int         ref_n = 0;
    int         last_idx = 0;

    always #5 clk = ~clk;

    addsub_seg_display #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .sum   (sum),
        .m     (m),
        .load  (load),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    function automatic logic [6:0] pat(int g);
        logic [6:0] t [14];
        t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100;
        t[3] = 7'b0110000; t[4] = 7'b0011001; t[5] = 7'b0010010;
        t[6] = 7'b0000010; t[7] = 7'b1111000; t[8] = 7'b0000000;
        t[9] = 7'b0010000; t[10] = 7'b0001000; t[11] = 7'b0010010;
        t[12] = 7'b0111111; t[13] = 7'b1111111;
        return t[g];
    endfunction

    // Glyph index (0-9, 10=A, 11=S, 12=minus, 13=blank) from plain arithmetic
    function automatic int digit_glyph(logic [4:0] s, logic mm, int d);
        int v, mag;
        v = int'(s);
        if (mm && s[4]) v = v - 32;
        mag = (v < 0) ? -v : v;
        case (d)
            3: return mm ? 11 : 10;
            2: return (v < 0) ? 12 : 13;
            1: return (mag / 10 == 0) ? 13 : mag / 10;
            default: return mag % 10;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle, then compare outputs with the reference model
    task automatic step(bit r, bit ld, logic [4:0] s, logic mm);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int idx;
        reset = r; load = ld; sum = s; m = mm;
        @(posedge clk);
        #1;
        if (r) begin
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            ref_sum = 5'd0;
            ref_m   = 1'b0;
            ref_n   = 0;
            last_idx = -1;
        end else begin
            idx     = (ref_n / DIV) % 4;
            exp_an  = ~(4'b0001 << idx);
            exp_seg = pat(digit_glyph(ref_sum, ref_m, idx));
            ref_n++;
            last_idx = idx;
            if (ld) begin
                ref_sum = s;
                ref_m   = mm;
            end
        end
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("dp", 32'(dp), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    vec_t vecs [8];

    initial begin
        // Table: {sum, m, digit0, digit1, digit2, digit3}
        vecs[0] = '{5'b01101, 1'b0, '{pat(3),  pat(1),  pat(13), pat(10)}};
        vecs[1] = '{5'b11110, 1'b1, '{pat(2),  pat(13), pat(12), pat(11)}};
        vecs[2] = '{5'b10001, 1'b1, '{pat(5),  pat(1),  pat(12), pat(11)}};
        vecs[3] = '{5'b11110, 1'b0, '{pat(0),  pat(3),  pat(13), pat(10)}};
        vecs[4] = '{5'b00000, 1'b1, '{pat(0),  pat(13), pat(13), pat(11)}};
        vecs[5] = '{5'b10000, 1'b1, '{pat(6),  pat(1),  pat(12), pat(11)}};
        vecs[6] = '{5'b01111, 1'b1, '{pat(5),  pat(1),  pat(13), pat(11)}};
        vecs[7] = '{5'b00000, 1'b0, '{pat(0),  pat(13), pat(13), pat(10)}};

        // Reset held for three cycles, with a load that reset must override
        step(1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b1, 5'b11111, 1'b1);
        step(1'b1, 1'b0, 5'd0, 1'b0);

        // First edge out of reset shows digit 0 of zero
        step(1'b0, 1'b0, 5'd0, 1'b0);
        check("first_an", 32'(an), 32'(4'b1110));
        check("first_seg", 32'(seg), 32'(7'b1000000));

        // Free-run scan: each enable held 4 cycles, then wrap to 1110
        for (int j = 1; j < 17; j++) begin
            logic [3:0] sc [4];
            sc[0] = 4'b1110; sc[1] = 4'b1101; sc[2] = 4'b1011; sc[3] = 4'b0111;
            step(1'b0, 1'b0, 5'd0, 1'b0);
            check("scan_an", 32'(an), 32'(sc[(j / DIV) % 4]));
        end

        // Table vectors: load, then watch two full scans
        foreach (vecs[v]) begin
            step(1'b0, 1'b1, vecs[v].sum, vecs[v].m);
            for (int c = 0; c < 16; c++) begin
                step(1'b0, 1'b0, 5'd0, 1'b0);
                check($sformatf("vec%0d_d%0d", v, last_idx), 32'(seg),
                      32'(vecs[v].digs[last_idx]));
            end
        end

        // Reset during the digit-2 dwell restarts at digit 0 for a full dwell
        step(1'b1, 1'b0, 5'd0, 1'b0);
        idle(9);
        check("pre_rst_an", 32'(an), 32'(4'b1011));
        step(1'b1, 1'b0, 5'd0, 1'b0);
        check("mid_rst_seg", 32'(seg), 32'(7'b1111111));
        step(1'b1, 1'b0, 5'd0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b0, 5'd0, 1'b0);
            check("restart_an", 32'(an), 32'(4'b1110));
        end
        step(1'b0, 1'b0, 5'd0, 1'b0);
        check("restart_next_an", 32'(an), 32'(4'b1101));

        // Load on the wrap edge: digit 1 appears already showing the new value
        step(1'b1, 1'b0, 5'd0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 5'b10110, 1'b0);
        step(1'b0, 1'b0, 5'd0, 1'b0);
        check("wrap_load_an", 32'(an), 32'(4'b1101));
        check("wrap_load_seg", 32'(seg), 32'(7'b0100100));

        // Randomized loads and occasional resets against the model
        for (int i = 0; i < 600; i++) begin
            bit r, ld;
            r  = ($urandom_range(0, 59) == 0);
            ld = ($urandom_range(0, 2) == 0);
            step(r, ld, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/addsub_seg_display.md
ADDSUB_SEG_DISPLAY -- requirements
Module: addsub_seg_display

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clock cycles each digit is held (1 kHz per digit at 100 MHz); SHALL be legal for any value >= 2.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: sum  input  5  result word from the 4-bit add/sub stage.
REQ-005 Port: m  input  1  mode of that result: 0 = add, 1 = subtract.
REQ-006 Port: load  input  1  single-cycle capture strobe for sum and m.
REQ-007 Port: an  output  4  digit enables, active-low; an[0] is the rightmost digit.
REQ-008 Port: seg  output  7  segments, active-low; seg[6:0] = g,f,e,d,c,b,a.
REQ-009 Port: dp  output  1  decimal point, active-low; SHALL be held constant 1 (off).

Function
REQ-010 load=1 at an edge SHALL capture sum and m into holding registers; load=0 SHALL hold the previous values.
REQ-011 m=0: the held sum SHALL be read as unsigned 0..30.
REQ-012 m=1: the held sum SHALL be read as 5-bit two's complement -16..15; magnitude = two's-complement negation when sum[4]=1.
REQ-013 Digit 3 SHALL show the mode letter: 'A' when m=0, 'S' when m=1.
REQ-014 Digit 2 SHALL show '-' when m=1 and sum[4]=1; otherwise blank.
REQ-015 Digit 1 SHALL show the magnitude tens digit, or blank when tens=0.
REQ-016 Digit 0 SHALL show the magnitude ones digit, including '0' for zero.
REQ-017 Magnitude 16 (m=1, sum=10000) SHALL display as '-','1','6'.
REQ-018 A refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap to 0.
REQ-019 A 2-bit scan index SHALL advance on each counter wrap, in the order 0,1,2,3,0.
REQ-020 Exactly one an bit SHALL be low at any time outside reset.
REQ-021 an and seg SHALL be registered.
REQ-022 an and seg SHALL reflect the scan index and held value with one-cycle latency.
REQ-023 A load accepted at edge k SHALL be visible on seg from edge k+1.
REQ-024 A load coinciding with a counter wrap SHALL apply both updates; the newly enabled digit SHALL show the new value.
REQ-025 Segment patterns (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, S=0010010, minus=0111111, blank=1111111.

Reset
REQ-026 While reset=1: an=1111, seg=1111111, dp=1, held sum=0, held m=0, counter=0, scan index=0.
REQ-027 reset SHALL take priority over load.
REQ-028 On the first edge after reset deasserts: an=1110, seg=digit 0 of the held value (0, pattern 1000000).
REQ-029 Reset asserted mid-scan SHALL restart the scan at digit 0 with a full REFRESH_DIV dwell.

Structure
REQ-030 Package addsub_disp_pkg SHALL hold the segment-pattern constants, the blank and minus codes, and the REFRESH_DIV default.
REQ-031 Sub-module seg7_decode SHALL be combinational, mapping a 5-bit glyph code (0-9, A, S, minus, blank) to seg.
REQ-032 Magnitude-to-tens/ones conversion SHALL be combinational, for values 0..30.

Verification (benches SHALL use REFRESH_DIV=4)
REQ-033 Reset held 3 cycles -> an=1111, seg=1111111, dp=1 throughout.
REQ-034 load with sum=01101, m=0 -> digits 3..0 = 0001000, 1111111, 1111001, 0110000 (A, blank, 1, 3).
REQ-035 load with sum=11110, m=1 -> digits 3..0 = S, minus, blank, 2; then load with sum=10001, m=1 -> S, minus, 1, 5.
REQ-036 load with sum=11110, m=0 -> A, blank, 3, 0; then load with sum=00000, m=1 -> S, blank, blank, 0.
REQ-037 Free-run scan -> an = 1110, 1101, 1011, 0111, each held exactly 4 cycles, then wraps to 1110.
REQ-038 Reset during the digit-2 dwell -> blank during reset, then an=1110 for a full 4 cycles.
REQ-039 load on a wrap edge -> the newly enabled digit shows the new value on the next cycle.
